// File: rtl/chien_root_search.sv
// Purpose : Chien root search for a Reed-Solomon decoder over GF(2^SYMB_WIDTH).
//           Evaluates the error locator at every non-zero field element in
//           parallel, extracts up to T_LEN roots, maps them to codeword error
//           positions and flags locators whose root count differs from their degree.
// Latency : 3 cycles, fully pipelined, one locator accepted per clock.
// Backpr. : none; error_locator_vld is always accepted and each accepted
//           locator yields exactly one error_positions_vld pulse.
//
// Ports:
//   aclk, aresetn (sync, active-low)   clock / reset
//   error_locator[T_LEN:0]             Lambda coefficients, [k] multiplies x^k
//   error_locator_vld                  input qualifier
//   error_positions[T_LEN-1:0]         error position per slot (descending order)
//   error_positions_mask               slot j holds a valid position
//   root_count                         number of roots found among alpha^0..alpha^(N-1)
//   error_positions_vld                one-cycle pulse qualifying all outputs
//   rs_chien_err                       root count does not match locator degree

module chien_root_search #(
    parameter int                  SYMB_WIDTH = 4,
    parameter int                  T_LEN      = 2,
    parameter logic [SYMB_WIDTH:0] PRIM_POLY  = 'h13
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    input  logic [T_LEN:0][SYMB_WIDTH-1:0]       error_locator,
    input  logic                                 error_locator_vld,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0]     error_positions,
    output logic [T_LEN-1:0]                     error_positions_mask,
    output logic [SYMB_WIDTH-1:0]                root_count,
    output logic                                 error_positions_vld,
    output logic                                 rs_chien_err
);

    // Number of non-zero field elements.
    localparam int N = (1 << SYMB_WIDTH) - 1;

    // Reduction term applied when a shift overflows the x^m position.
    localparam logic [SYMB_WIDTH-1:0] POLY_LOW = PRIM_POLY[SYMB_WIDTH-1:0];

    // Position of root index i is (2^m - 2) - i, i.e. the exponent of alpha^-i
    // expressed as a distance from the last codeword symbol.
    localparam logic [SYMB_WIDTH-1:0] POS_BASE = SYMB_WIDTH'((1 << SYMB_WIDTH) - 2);

    // ------------------------------------------------------------------
    // Field arithmetic helpers
    // ------------------------------------------------------------------

    // Shift-and-add GF multiply: carry-less product reduced on the fly.
    function automatic logic [SYMB_WIDTH-1:0] gf_mul(
        input logic [SYMB_WIDTH-1:0] a,
        input logic [SYMB_WIDTH-1:0] b
    );
        logic [SYMB_WIDTH-1:0] acc;
        logic [SYMB_WIDTH-1:0] aa;
        acc = '0;
        aa  = a;
        for (int k = 0; k < SYMB_WIDTH; k++) begin
            if (b[k]) begin
                acc = acc ^ aa;
            end
            if (aa[SYMB_WIDTH-1]) begin
                aa = (aa << 1) ^ POLY_LOW;
            end else begin
                aa = aa << 1;
            end
        end
        return acc;
    endfunction

    // alpha^i for i = 0..N-1, alpha = x (encoded 2). Built at elaboration.
    function automatic logic [N-1:0][SYMB_WIDTH-1:0] gen_roots();
        logic [N-1:0][SYMB_WIDTH-1:0] tbl;
        logic [SYMB_WIDTH-1:0]        p;
        tbl = '0;
        p   = SYMB_WIDTH'(1);
        for (int i = 0; i < N; i++) begin
            tbl[i] = p;
            p      = gf_mul(p, SYMB_WIDTH'(2));
        end
        return tbl;
    endfunction

    localparam logic [N-1:0][SYMB_WIDTH-1:0] ROOTS = gen_roots();

    // Horner evaluation of Lambda at x. Leading zero coefficients only
    // multiply a zero accumulator, so they drop out naturally.
    function automatic logic [SYMB_WIDTH-1:0] gf_poly_eval(
        input logic [T_LEN:0][SYMB_WIDTH-1:0] coef,
        input logic [SYMB_WIDTH-1:0]          x
    );
        logic [SYMB_WIDTH-1:0] acc;
        acc = '0;
        for (int k = T_LEN; k >= 0; k--) begin
            acc = gf_mul(acc, x) ^ coef[k];
        end
        return acc;
    endfunction

    // Peel the lowest T_LEN set bits off v, one one-hot vector per slot.
    // Slots left without a bit come out all-zero; extra bits are dropped.
    function automatic logic [T_LEN-1:0][N-1:0] lib_decmps_to_pow2(
        input logic [N-1:0] v
    );
        logic [N-1:0]            rem;
        logic [T_LEN-1:0][N-1:0] oh;
        rem = v;
        oh  = '0;
        for (int j = 0; j < T_LEN; j++) begin
            // Two's-complement trick isolates the lowest set bit.
            oh[j] = rem & (~rem + N'(1));
            rem   = rem & ~oh[j];
        end
        return oh;
    endfunction

    // Encode a one-hot vector back to its bit index (0 for an empty vector).
    function automatic logic [SYMB_WIDTH-1:0] lib_mux_onehot(
        input logic [N-1:0] oh
    );
        logic [SYMB_WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            idx = idx | ({SYMB_WIDTH{oh[i]}} & SYMB_WIDTH'(i));
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: parallel evaluation -> root vector, locator degree
    // ------------------------------------------------------------------
    logic [N-1:0]          w_hit;
    logic [SYMB_WIDTH-1:0] w_deg;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N; i++) begin
            w_hit[i] = (gf_poly_eval(error_locator, ROOTS[i]) == '0);
        end
    end

    // Highest non-zero coefficient; constant or all-zero locators give 0.
    always_comb begin
        w_deg = '0;
        for (int k = 0; k <= T_LEN; k++) begin
            if (error_locator[k] != '0) begin
                w_deg = SYMB_WIDTH'(k);
            end
        end
    end

    logic                  r_s1_vld;
    logic [N-1:0]          r_s1_hit;
    logic [SYMB_WIDTH-1:0] r_s1_deg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s1_vld <= 1'b0;
            r_s1_hit <= '0;
            r_s1_deg <= '0;
        end else begin
            r_s1_vld <= error_locator_vld;
            if (error_locator_vld) begin
                r_s1_hit <= w_hit;
                r_s1_deg <= w_deg;
            end else begin
                r_s1_hit <= '0;
                r_s1_deg <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: slot decomposition, root count, degree check
    // ------------------------------------------------------------------
    logic [T_LEN-1:0][N-1:0] w_onehot;
    logic [T_LEN-1:0]        w_mask;
    logic [SYMB_WIDTH-1:0]   w_cnt;
    logic                    w_err;

    always_comb begin
        w_onehot = lib_decmps_to_pow2(r_s1_hit);
        w_mask   = '0;
        for (int j = 0; j < T_LEN; j++) begin
            w_mask[j] = |w_onehot[j];
        end
    end

    // N < 2^m, so the count always fits without saturation.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_cnt = w_cnt + SYMB_WIDTH'(r_s1_hit[i]);
        end
    end

    // A zero locator reports every element as a root and lands here too.
    assign w_err = (w_cnt != r_s1_deg);

    logic                    r_s2_vld;
    logic [T_LEN-1:0][N-1:0] r_s2_onehot;
    logic [T_LEN-1:0]        r_s2_mask;
    logic [SYMB_WIDTH-1:0]   r_s2_cnt;
    logic                    r_s2_err;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s2_vld    <= 1'b0;
            r_s2_onehot <= '0;
            r_s2_mask   <= '0;
            r_s2_cnt    <= '0;
            r_s2_err    <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_onehot <= w_onehot;
                r_s2_mask   <= w_mask;
                r_s2_cnt    <= w_cnt;
                r_s2_err    <= w_err;
            end else begin
                r_s2_onehot <= '0;
                r_s2_mask   <= '0;
                r_s2_cnt    <= '0;
                r_s2_err    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: index selection and conversion to codeword positions
    // ------------------------------------------------------------------
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] w_pos;

    always_comb begin
        w_pos = '0;
        for (int j = 0; j < T_LEN; j++) begin
            if (r_s2_mask[j]) begin
                w_pos[j] = POS_BASE - lib_mux_onehot(r_s2_onehot[j]);
            end
        end
    end

    logic                             r_s3_vld;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] r_s3_pos;
    logic [T_LEN-1:0]                 r_s3_mask;
    logic [SYMB_WIDTH-1:0]            r_s3_cnt;
    logic                             r_s3_err;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_s3_vld  <= 1'b0;
            r_s3_pos  <= '0;
            r_s3_mask <= '0;
            r_s3_cnt  <= '0;
            r_s3_err  <= 1'b0;
        end else begin
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_s3_pos  <= w_pos;
                r_s3_mask <= r_s2_mask;
                r_s3_cnt  <= r_s2_cnt;
                r_s3_err  <= r_s2_err;
            end else begin
                r_s3_pos  <= '0;
                r_s3_mask <= '0;
                r_s3_cnt  <= '0;
                r_s3_err  <= 1'b0;
            end
        end
    end

    assign error_positions      = r_s3_pos;
    assign error_positions_mask = r_s3_mask;
    assign root_count           = r_s3_cnt;
    assign error_positions_vld  = r_s3_vld;
    assign rs_chien_err         = r_s3_err;

endmodule

// File: tb/tb_chien_root_search.sv
module tb_chien_root_search;

    logic                  aclk;
    logic                  aresetn;
    logic [2:0][3:0]       error_locator;
    logic                  error_locator_vld;
    logic [1:0][3:0]       error_positions;
    logic [1:0]            error_positions_mask;
    logic [3:0]            root_count;
    logic                  error_positions_vld;
    logic                  rs_chien_err;

    chien_root_search #(
        .SYMB_WIDTH (4),
        .T_LEN      (2),
        .PRIM_POLY  (5'h13)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .error_locator        (error_locator),
        .error_locator_vld    (error_locator_vld),
        .error_positions      (error_positions),
        .error_positions_mask (error_positions_mask),
        .root_count           (root_count),
        .error_positions_vld  (error_positions_vld),
        .rs_chien_err         (rs_chien_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Expected output bundle.
    typedef struct packed {
        logic       vld;
        logic [1:0] mask;
        logic [3:0] p1;
        logic [3:0] p0;
        logic [3:0] cnt;
        logic       err;
    } exp_t;

    typedef struct packed {
        logic [2:0][3:0] loc;
        exp_t            e;
    } vec_t;

    typedef struct {
        exp_t  e;
        string tag;
    } pend_t;

    int    checks = 0;
    int    errors = 0;
    pend_t pipe[$];

    // GF(16) exp/log tables for the reference model.
    int gexp[0:14];
    int glog[0:15];

    function automatic exp_t mk(input logic vld, input logic [1:0] mask, input int p0,
                                input int p1, input int cnt, input logic err);
        exp_t e;
        e.vld  = vld;
        e.mask = mask;
        e.p0   = 4'(p0);
        e.p1   = 4'(p1);
        e.cnt  = 4'(cnt);
        e.err  = err;
        return e;
    endfunction

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 15];
    endfunction

    // Reference: evaluate Lambda at each alpha^i as a sum of terms, collect
    // roots in ascending index, first two fill the slots.
    function automatic exp_t model(input logic [2:0][3:0] loc);
        exp_t e;
        int   deg, cnt, v, xp;
        e     = '0;
        e.vld = 1'b1;
        deg   = 0;
        cnt   = 0;
        for (int k = 0; k < 3; k++) if (loc[k] != 0) deg = k;
        for (int i = 0; i < 15; i++) begin
            v  = 0;
            xp = 1;
            for (int k = 0; k < 3; k++) begin
                v  = v ^ gmul(int'(loc[k]), xp);
                xp = gmul(xp, gexp[i]);
            end
            if (v == 0) begin
                if (cnt == 0) begin e.p0 = 4'(14 - i); e.mask[0] = 1'b1; end
                else if (cnt == 1) begin e.p1 = 4'(14 - i); e.mask[1] = 1'b1; end
                cnt++;
            end
        end
        e.cnt = 4'(cnt);
        e.err = (cnt != deg);
        return e;
    endfunction

    task automatic check(input exp_t want, input string tag);
        exp_t got;
        got = {error_positions_vld, error_positions_mask, error_positions[1],
               error_positions[0], root_count, rs_chien_err};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got vld=%0b mask=%b pos0=%0d pos1=%0d cnt=%0d err=%0b, want vld=%0b mask=%b pos0=%0d pos1=%0d cnt=%0d err=%0b",
                     tag, got.vld, got.mask, got.p0, got.p1, got.cnt, got.err,
                     want.vld, want.mask, want.p0, want.p1, want.cnt, want.err);
        end
    endtask

    // One clock: check the output due now (from 3 cycles ago), then drive
    // this cycle's inputs and queue what they should produce.
    task automatic step(input logic rst_n, input logic vld, input logic [2:0][3:0] loc,
                        input exp_t e, input string tag);
        pend_t p;
        pend_t z;
        @(posedge aclk);
        #1;
        p = pipe.pop_front();
        check(p.e, p.tag);
        aresetn           = rst_n;
        error_locator_vld = vld;
        error_locator     = loc;
        if (!rst_n) begin
            // Everything in flight is wiped at this edge.
            pipe.delete();
            z.e   = '0;
            z.tag = {tag, "_flushed"};
            repeat (3) pipe.push_back(z);
        end else begin
            z.e   = vld ? e : exp_t'('0);
            z.tag = tag;
            pipe.push_back(z);
        end
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, tag);
    endtask

    vec_t vt[8];

    initial begin
        logic [2:0][3:0] loc;
        pend_t           z;
        int              x, a, b, r;

        aresetn           = 1'b0;
        error_locator_vld = 1'b0;
        error_locator     = '0;

        x = 1;
        for (int i = 0; i < 15; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 16) != 0) x = x ^ 'h13;
        end
        glog[0] = 0;

        // Lambda written {c2, c1, c0}.
        vt[0] = '{loc: {4'd0, 4'd1,  4'd1}, e: mk(1, 2'b01, 14, 0, 1, 0)};   // 1+x
        vt[1] = '{loc: {4'd5, 4'd14, 4'd1}, e: mk(1, 2'b11, 4, 2, 2, 0)};    // roots a^10, a^12
        vt[2] = '{loc: {4'd1, 4'd0,  4'd1}, e: mk(1, 2'b01, 14, 0, 1, 1)};   // (1+x)^2
        vt[3] = '{loc: {4'd0, 4'd0,  4'd0}, e: mk(1, 2'b11, 14, 13, 15, 1)}; // zero locator
        vt[4] = '{loc: {4'd0, 4'd0,  4'd1}, e: mk(1, 2'b00, 0, 0, 0, 0)};    // constant 1
        vt[5] = '{loc: {4'd0, 4'd2,  4'd1}, e: mk(1, 2'b01, 0, 0, 1, 0)};    // root a^14 -> pos 0
        vt[6] = '{loc: {4'd0, 4'd1,  4'd0}, e: mk(1, 2'b00, 0, 0, 0, 1)};    // Lambda = x
        vt[7] = '{loc: {4'd0, 4'd0,  4'd5}, e: mk(1, 2'b00, 0, 0, 0, 0)};    // constant 5

        z.e   = '0;
        z.tag = "reset_state";
        repeat (3) pipe.push_back(z);

        // Held in reset: outputs must stay 0.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, {4'd0, 4'd1, 4'd1}, '0, "reset_state");
        idle(3, "post_reset_idle");

        // Table vectors, separated by one idle cycle.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, vt[i].loc, vt[i].e, $sformatf("vec%0d", i));
            idle(1, $sformatf("vec%0d_gap", i));
        end
        idle(3, "table_drain");

        // Back-to-back: constant locator then two-root locator.
        step(1'b1, 1'b1, vt[4].loc, vt[4].e, "b2b_first");
        step(1'b1, 1'b1, vt[1].loc, vt[1].e, "b2b_second");
        idle(4, "b2b_drain");

        // Reset mid-flight: two inputs, reset for one cycle, nothing emerges.
        step(1'b1, 1'b1, vt[0].loc, vt[0].e, "midrst_in0");
        step(1'b1, 1'b1, vt[1].loc, vt[1].e, "midrst_in1");
        step(1'b0, 1'b0, '0, '0, "midrst");
        idle(2, "midrst_quiet");
        step(1'b1, 1'b1, vt[1].loc, vt[1].e, "after_rst");
        idle(4, "after_rst_drain");

        // Randomized locators against the reference model.
        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(1, 15);
            b = $urandom_range(1, 15);
            r = $urandom_range(0, 4);
            loc = '0;
            case (r)
                0, 1: begin   // product of two root factors (possibly repeated)
                    loc[0] = 4'd1;
                    loc[1] = 4'(a ^ b);
                    loc[2] = 4'(gmul(a, b));
                end
                2: begin      // single root factor
                    loc[0] = 4'd1;
                    loc[1] = 4'(a);
                end
                3: begin      // arbitrary coefficients
                    loc[0] = 4'($urandom_range(0, 15));
                    loc[1] = 4'($urandom_range(0, 15));
                    loc[2] = 4'($urandom_range(0, 15));
                end
                default: begin // repeated root
                    loc[0] = 4'd1;
                    loc[2] = 4'(gmul(a, a));
                end
            endcase
            if ($urandom_range(0, 9) < 7)
                step(1'b1, 1'b1, loc, model(loc), $sformatf("rand%0d", n));
            else
                step(1'b1, 1'b0, loc, '0, $sformatf("rand%0d_idle", n));
        end
        idle(4, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
